reg_file_read_64: RTL and testbench

- 32-entry x 64-bit architectural register file for the out-of-order pipe; the read-side counterpart to the per-register enable-write storage.
- One synchronous write port (writeback); two registered read ports (operand fetch) with write-to-read bypass; per-register busy scoreboard for issue readiness.
- Sits between rename/issue (reads, busy set) and writeback (writes, busy clear).

---
 rtl/reg_file_read_64.sv | 103 ++++++++++
 tb/tb_reg_file_read_64.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_read_64.sv
// 32 x 64 register file: one write port, two registered read ports, and a per-register busy scoreboard.
// Define READ_BYPASS_EN to forward same-cycle write data and ready onto a matching read port.
module reg_file_read_64 #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     softReset,
   input  logic                     wrEn,
   input  logic [$clog2(DEPTH)-1:0] wrAddr,
   input  logic [WIDTH-1:0]         wrData,
   input  logic                     rdEn,
   input  logic [$clog2(DEPTH)-1:0] rdAddrA,
   input  logic [$clog2(DEPTH)-1:0] rdAddrB,
   output logic [WIDTH-1:0]         rdDataA,
   output logic [WIDTH-1:0]         rdDataB,
   output logic                     rdValid,
   output logic                     rdReadyA,
   output logic                     rdReadyB,
   input  logic                     setBusy,
   input  logic [$clog2(DEPTH)-1:0] setAddr
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;

   logic             wr_hit;
   logic             set_hit;
   logic [AW-1:0]    rd_addr   [2];
   logic [WIDTH-1:0] nxt_data  [2];
   logic             nxt_ready [2];

   // Writes and busy marks aimed at the hardwired zero register are dropped here.
   assign wr_hit     = wrEn    && !((ZERO_REG != 0) && (wrAddr  == '0));
   assign set_hit    = setBusy && !((ZERO_REG != 0) && (setAddr == '0));
   assign rd_addr[0] = rdAddrA;
   assign rd_addr[1] = rdAddrB;

   // NOTE: every output of this block gets its default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         nxt_data[p]  = regs[rd_addr[p]];
         nxt_ready[p] = ~busy[rd_addr[p]];
`ifdef READ_BYPASS_EN
         if (wr_hit && (wrAddr == rd_addr[p])) begin
            nxt_data[p]  = wrData;
            nxt_ready[p] = !(set_hit && (setAddr == wrAddr));
         end
`endif
         if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
            nxt_data[p]  = '0;
            nxt_ready[p] = 1'b1;
         end
      end
   end

   // NOTE: the storage array is reset on purpose, because reset must leave every architectural register at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else if (softReset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_hit) begin
            regs[wrAddr] <= wrData;
            busy[wrAddr] <= 1'b0;
         end
         // NOTE: with non-blocking assignments the later one wins, so a new producer overrides the writeback clear.
         if (set_hit) busy[setAddr] <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdDataA  <= '0;
         rdDataB  <= '0;
         rdReadyA <= 1'b0;
         rdReadyB <= 1'b0;
         rdValid  <= 1'b0;
      end else if (softReset) begin
         rdDataA  <= '0;
         rdDataB  <= '0;
         rdReadyA <= 1'b0;
         rdReadyB <= 1'b0;
         rdValid  <= 1'b0;
      end else if (rdEn) begin
         rdDataA  <= nxt_data[0];
         rdDataB  <= nxt_data[1];
         rdReadyA <= nxt_ready[0];
         rdReadyB <= nxt_ready[1];
         rdValid  <= 1'b1;
      end else begin
         rdValid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file_read_64.sv
// Self-checking bench for reg_file_read_64: directed scenarios followed by random traffic.
// The expected values come from an array-based model of the register file.
module tb_reg_file_read_64;

   logic        clk = 1'b0;
   logic        reset;
   logic        softReset;
   logic        wrEn;
   logic [4:0]  wrAddr;
   logic [63:0] wrData;
   logic        rdEn;
   logic [4:0]  rdAddrA;
   logic [4:0]  rdAddrB;
   logic [63:0] rdDataA;
   logic [63:0] rdDataB;
   logic        rdValid;
   logic        rdReadyA;
   logic        rdReadyB;
   logic        setBusy;
   logic [4:0]  setAddr;

   int tests = 0;
   int fails = 0;

   logic [63:0] m_mem  [32];
   bit          m_busy [32];
   logic [63:0] e_data [2];
   logic        e_ready[2];
   logic        e_valid;

`ifdef READ_BYPASS_EN
   localparam logic [63:0] BYP_EXP = 64'h2;
`else
   localparam logic [63:0] BYP_EXP = 64'h1;
`endif

   reg_file_read_64 dut (
      .clk(clk), .reset(reset), .softReset(softReset),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .rdEn(rdEn), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
      .rdDataA(rdDataA), .rdDataB(rdDataB), .rdValid(rdValid),
      .rdReadyA(rdReadyA), .rdReadyB(rdReadyB),
      .setBusy(setBusy), .setAddr(setAddr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_valid"},  {63'd0, rdValid},  {63'd0, e_valid});
      check({tag, "_dataA"},  rdDataA,           e_data[0]);
      check({tag, "_dataB"},  rdDataB,           e_data[1]);
      check({tag, "_readyA"}, {63'd0, rdReadyA}, {63'd0, e_ready[0]});
      check({tag, "_readyB"}, {63'd0, rdReadyB}, {63'd0, e_ready[1]});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      e_data[0] = '0;  e_data[1] = '0;
      e_ready[0] = 1'b0; e_ready[1] = 1'b0;
      e_valid = 1'b0;
   endtask

   // Applies the architectural rules for one clock edge using the currently driven inputs.
   task automatic model_edge();
      logic [4:0] a;
      if (softReset) begin
         model_reset();
         return;
      end
      if (rdEn) begin
         for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? rdAddrA : rdAddrB;
            if (a == 0) begin
               e_data[p] = '0;
               e_ready[p] = 1'b1;
            end else begin
               e_data[p] = m_mem[a];
               e_ready[p] = !m_busy[a];
`ifdef READ_BYPASS_EN
               if (wrEn && wrAddr == a) begin
                  e_data[p] = wrData;
                  e_ready[p] = !(setBusy && setAddr == a);
               end
`endif
            end
         end
         e_valid = 1'b1;
      end else begin
         e_valid = 1'b0;
      end
      if (wrEn && wrAddr != 0) begin
         m_mem[wrAddr]  = wrData;
         m_busy[wrAddr] = 1'b0;
      end
      if (setBusy && setAddr != 0) m_busy[setAddr] = 1'b1;
   endtask

   task automatic idle();
      softReset = 1'b0; wrEn = 1'b0; rdEn = 1'b0; setBusy = 1'b0;
      wrAddr = '0; wrData = '0; rdAddrA = '0; rdAddrB = '0; setAddr = '0;
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [63:0] d);
      idle(); wrEn = 1'b1; wrAddr = a; wrData = d;
      tick("write");
   endtask

   task automatic do_read(input logic [4:0] a, input logic [4:0] b);
      idle(); rdEn = 1'b1; rdAddrA = a; rdAddrB = b;
      tick("read");
   endtask

   task automatic do_busy(input logic [4:0] a);
      idle(); setBusy = 1'b1; setAddr = a;
      tick("busy");
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      #3;
      check_all("por");
      @(negedge clk);
      reset = 1'b0;

      // Asynchronous reset between edges.
      do_write(5, 64'hDEAD_BEEF);
      do_read(5, 5);
      check("pre_async_dataA", rdDataA, 64'hDEAD_BEEF);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async");
      @(negedge clk);
      reset = 1'b0;
      do_read(5, 5);
      check("post_async_dataA", rdDataA, 64'h0);
      check("post_async_readyA", {63'd0, rdReadyA}, 64'd1);

      // Basic write then read, then hold.
      do_write(7, 64'h1F);
      do_write(9, 64'hFFFF_0000_FFFF_0000);
      do_read(7, 9);
      check("wr_rd_dataA", rdDataA, 64'h1F);
      check("wr_rd_dataB", rdDataB, 64'hFFFF_0000_FFFF_0000);
      idle();
      tick("hold");
      check("hold_valid", {63'd0, rdValid}, 64'd0);
      check("hold_dataB", rdDataB, 64'hFFFF_0000_FFFF_0000);

      // Zero register.
      do_write(0, 64'h1234);
      do_read(0, 7);
      check("zero_dataA", rdDataA, 64'h0);
      check("zero_readyA", {63'd0, rdReadyA}, 64'd1);
      do_busy(0);
      do_read(0, 0);
      check("zero_busy_readyA", {63'd0, rdReadyA}, 64'd1);

      // Scoreboard.
      do_busy(3);
      do_read(3, 7);
      check("sb_busy_readyA", {63'd0, rdReadyA}, 64'd0);
      do_write(3, 64'h55);
      do_read(3, 3);
      check("sb_clr_readyA", {63'd0, rdReadyA}, 64'd1);
      check("sb_clr_dataA", rdDataA, 64'h55);
      idle(); wrEn = 1'b1; wrAddr = 3; wrData = 64'h55; setBusy = 1'b1; setAddr = 3;
      tick("sb_both");
      do_read(3, 3);
      check("sb_both_readyA", {63'd0, rdReadyA}, 64'd0);
      check("sb_both_dataA", rdDataA, 64'h55);

      // Same-cycle read and write.
      do_write(12, 64'h1);
      idle(); wrEn = 1'b1; wrAddr = 12; wrData = 64'h2; rdEn = 1'b1; rdAddrA = 12; rdAddrB = 12;
      tick("rw_same");
      check("rw_same_dataA", rdDataA, BYP_EXP);
      do_read(12, 0);
      check("rw_next_dataA", rdDataA, 64'h2);

      // Synchronous soft reset wins over everything else in its cycle.
      do_busy(20);
      do_busy(21);
      idle();
      softReset = 1'b1; wrEn = 1'b1; wrAddr = 4; wrData = 64'hAA;
      rdEn = 1'b1; rdAddrA = 4; rdAddrB = 20; setBusy = 1'b1; setAddr = 22;
      tick("soft");
      check("soft_valid", {63'd0, rdValid}, 64'd0);
      do_read(4, 20);
      check("soft_r4", rdDataA, 64'h0);
      check("soft_r20_ready", {63'd0, rdReadyB}, 64'd1);
      do_read(21, 22);
      check("soft_r21_ready", {63'd0, rdReadyA}, 64'd1);
      check("soft_r22_ready", {63'd0, rdReadyB}, 64'd1);

      // Random traffic on a narrow address range to force collisions.
      for (int n = 0; n < 400; n++) begin
         softReset = ($urandom_range(0, 63) == 0);
         wrEn      = $urandom_range(0, 1);
         wrAddr    = 5'($urandom_range(0, 7));
         wrData    = {$urandom, $urandom};
         rdEn      = $urandom_range(0, 2) != 0;
         rdAddrA   = 5'($urandom_range(0, 7));
         rdAddrB   = 5'($urandom_range(0, 7));
         setBusy   = $urandom_range(0, 2) == 0;
         setAddr   = 5'($urandom_range(0, 7));
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
